dp_arbiter: RTL and testbench
=============================

# dp_arbiter

Round-robin arbiter that shares the single instruction datapath between up to `N_REQ` client FSMs (poison/food draw, creature update, etc.). Each client connects to one arbiter port with the same start/instruction/finished/result handshake it would use on the datapath directly. The arbiter captures each client's instruction, serialises issue to the datapath, and routes completion back to the owning client. It sits between the client FSMs and the datapath top.

## Interface

Parameters:

- `N_REQ`, default 4: number of client ports.
- `GRANT_WIDTH`, default 2: width of `grant_id`; must satisfy 2^`GRANT_WIDTH` ≥ `N_REQ`.
- `INSTR_WIDTH`, default `` `INSTRUCTION_WIDTH ``: instruction word width.
- `RES_WIDTH`, default `` `RESULT_WIDTH ``: result word width.

Ports:

- `clock`, in, 1: clock. All state updates on the rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `req_start`, in, `N_REQ`: per-client start request.
- `req_instruction`, in, `N_REQ`*`INSTR_WIDTH`: client i's instruction occupies bits [i*`INSTR_WIDTH` +: `INSTR_WIDTH`].
- `req_finished`, out, `N_REQ`: per-client idle/done flag.
- `req_result`, out, `RES_WIDTH`: shared result bus, valid for client i when `req_finished[i]` rises.
- `dp_start`, out, 1: datapath start.
- `dp_instruction`, out, `INSTR_WIDTH`: datapath instruction.
- `dp_finished`, in, 1: datapath idle/done flag.
- `dp_result`, in, `RES_WIDTH`: datapath result.
- `grant_id`, out, `GRANT_WIDTH`: index of the client currently owning the datapath.
- `busy`, out, 1: high while any operation is issued or outstanding on the datapath.

## Operation

- Per-client capture. On any edge where `req_start[i]`=1, `pending[i]`=0 and `req_finished[i]`=1:
  - latch instruction i into `ibuf[i]`;
  - set `pending[i]`;
  - clear `req_finished[i]`.
- `req_start[i]` is ignored while `pending[i]`=1. This makes a 2-cycle client start pulse count as one request.
- Issue FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any `pending` bit is set, select the first pending index searching upward from `last_grant`+1, modulo `N_REQ`.
  - Load `grant_id`, drive `dp_instruction` from `ibuf[grant]`, set `dp_start`=1 and `busy`=1, then go to ISSUE.
  - Otherwise hold.
- ISSUE: keep `dp_start`=1, go to WAIT.
- WAIT:
  - Set `dp_start`=0.
  - When `dp_finished`=1: `req_result` ← `dp_result`, `req_finished[grant]` ← 1, `pending[grant]` ← 0, `last_grant` ← `grant`, `busy` ← 0, go to IDLE.
- `dp_instruction` and `grant_id` hold their values until the next grant.
- `req_result` changes only on completion. Non-owning clients ignore it.
- Only one datapath operation is outstanding at a time. There is no timeout: WAIT blocks indefinitely until `dp_finished`.

## Timing

- Reset values:
  - `dp_start`=0, `dp_instruction`=0, `req_result`=0, `grant_id`=0, `busy`=0;
  - `req_finished`=all ones, `pending`=0;
  - `last_grant`=`N_REQ`-1, so client 0 has first priority;
  - FSM=IDLE.
- Reset mid-operation (any state) returns immediately to the reset values above. A datapath operation in flight is abandoned.
- `req_finished[i]` goes low in the cycle after `req_start[i]` is first sampled high. A client that checks finished 2 cycles after raising start therefore sees 0.
- Latency with the arbiter idle: `req_start[i]` first high in cycle c → `dp_start` high in cycles c+2 and c+3, low from c+4.
- `dp_start` is always high for exactly 2 consecutive cycles per grant. `dp_instruction` is stable from the first of those cycles until the next grant.
- Completion: `dp_finished` sampled high in WAIT at cycle w → `req_finished[g]`=1 and `req_result` valid in cycle w+1; FSM is in IDLE in w+1.
- A new grant may issue at the w+1 edge. Minimum gap between grants is 3 cycles plus the datapath latency.
- Simultaneous captures on several ports in the same edge are all accepted.
- A capture on a port in the same edge as another port's completion is accepted.
- A client whose `req_finished` just rose may capture again on the next edge.
- Fairness: with all ports continuously pending, grants rotate 0,1,2,3,0,…; no port waits more than `N_REQ`-1 grants.

## Test plan

- Single request: client 1 pulses start for 2 cycles with instr 0x1234; datapath returns 0xAB after 5 cycles → `dp_instruction`=0x1234 with `dp_start` high exactly 2 cycles; `req_finished[1]` rises with `req_result`=0xAB; other `req_finished` bits stay 1.
- Simultaneous: clients 0 and 2 start in the same cycle after reset → client 0 is served first, then client 2; each gets its own result (0x11 and 0x22).
- Round-robin: all four clients re-request immediately on finish for 12 grants → `grant_id` sequence 0,1,2,3 repeating; no client starves.
- Request while busy: client 3 starts during client 0's WAIT → `req_finished[3]` drops next cycle; `dp_start` for client 3 rises only after client 0 completes; client 3's instruction is preserved.
- Reset mid-WAIT: assert `resetn`=0 for 1 cycle while client 2 is outstanding → all outputs at reset values the next cycle; a subsequent client 2 request is served normally.
- Back-to-back same client: client 1 restarts the cycle after `req_finished[1]` rises → a second grant to client 1 with the correct new instruction; no duplicate issue from the 2-cycle start pulse.

Source files
------------

// File: rtl/dp_arbiter.sv
// dp_arbiter
// Round-robin arbiter that lets several client FSMs share one instruction
// datapath. Each client uses the same start/instruction/finished/result
// handshake that it would use on the datapath directly. The arbiter captures
// each client's instruction, issues one operation at a time to the datapath,
// and routes the completion back to the client that owns it.
//
// Ports
//   clock            rising-edge clock
//   resetn           synchronous, active-low reset
//   req_start        per-client start request
//   req_instruction  client i instruction at [i*INSTR_WIDTH +: INSTR_WIDTH]
//   req_finished     per-client idle/done flag (all ones when idle)
//   req_result       shared result bus, valid for client i when its finished rises
//   dp_start         datapath start; high for exactly two cycles per grant
//   dp_instruction   instruction of the current grant, held until the next grant
//   dp_finished      datapath idle/done flag
//   dp_result        datapath result
//   grant_id         index of the client that owns the datapath
//   busy             high while an operation is issued or outstanding

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module dp_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GRANT_WIDTH = 2,
    parameter int INSTR_WIDTH = `INSTRUCTION_WIDTH,
    parameter int RES_WIDTH   = `RESULT_WIDTH
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [N_REQ-1:0]             req_start,
    input  logic [N_REQ*INSTR_WIDTH-1:0] req_instruction,
    output logic [N_REQ-1:0]             req_finished,
    output logic [RES_WIDTH-1:0]         req_result,
    output logic                         dp_start,
    output logic [INSTR_WIDTH-1:0]       dp_instruction,
    input  logic                         dp_finished,
    input  logic [RES_WIDTH-1:0]         dp_result,
    output logic [GRANT_WIDTH-1:0]       grant_id,
    output logic                         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   r_state,     w_state_nx;
    logic [N_REQ-1:0]         r_pending,   w_pending_nx;
    logic [N_REQ-1:0]         r_finished,  w_finished_nx;
    logic [GRANT_WIDTH-1:0]   r_grant,     w_grant_nx;
    logic [GRANT_WIDTH-1:0]   r_last,      w_last_nx;
    logic                     r_dp_start,  w_dp_start_nx;
    logic                     r_busy,      w_busy_nx;
    logic [INSTR_WIDTH-1:0]   r_dp_instr,  w_dp_instr_nx;
    logic [RES_WIDTH-1:0]     r_result,    w_result_nx;
    logic [INSTR_WIDTH-1:0]   r_ibuf [N_REQ];

    logic [N_REQ-1:0]         w_capture;
    logic [N_REQ-1:0]         w_grant_oh;
    logic                     w_found_hi;
    logic                     w_found_lo;
    logic [GRANT_WIDTH-1:0]   w_sel_hi;
    logic [GRANT_WIDTH-1:0]   w_sel_lo;
    logic [GRANT_WIDTH-1:0]   w_sel;
    logic                     w_any_pending;
    logic [INSTR_WIDTH-1:0]   w_sel_instr;

    // A client is accepted only when idle; while pending, further start
    // cycles (e.g. the second cycle of a 2-cycle pulse) are ignored.
    assign w_capture = req_start & ~r_pending & r_finished;

    // Round-robin pick: the lowest pending index above last_grant wins;
    // if there is none, wrap around to the lowest pending index overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (r_pending[j]) begin
                if (!w_found_hi && (j > 32'(r_last))) begin
                    w_found_hi = 1'b1;
                    w_sel_hi   = GRANT_WIDTH'(j);
                end
                if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_sel_lo   = GRANT_WIDTH'(j);
                end
            end
        end
        w_any_pending = w_found_lo;
        w_sel         = w_found_hi ? w_sel_hi : w_sel_lo;
    end

    always_comb begin
        w_sel_instr = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (GRANT_WIDTH'(j) == w_sel) begin
                w_sel_instr = r_ibuf[j];
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_grant_oh[j] = (GRANT_WIDTH'(j) == r_grant);
        end
    end

    // Next-state and registered-output logic. Captures merge into pending /
    // finished every cycle; a capture can never hit the granted client in
    // its completion cycle because that client is still pending then.
    always_comb begin
        w_state_nx    = r_state;
        w_pending_nx  = r_pending | w_capture;
        w_finished_nx = r_finished & ~w_capture;
        w_grant_nx    = r_grant;
        w_last_nx     = r_last;
        w_dp_start_nx = r_dp_start;
        w_dp_instr_nx = r_dp_instr;
        w_result_nx   = r_result;
        w_busy_nx     = r_busy;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_pending) begin
                    w_grant_nx    = w_sel;
                    w_dp_instr_nx = w_sel_instr;
                    w_dp_start_nx = 1'b1;
                    w_busy_nx     = 1'b1;
                    w_state_nx    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_dp_start_nx = 1'b1;
                w_state_nx    = S_WAIT;
            end
            S_WAIT: begin
                w_dp_start_nx = 1'b0;
                if (dp_finished) begin
                    w_result_nx   = dp_result;
                    w_finished_nx = w_finished_nx | w_grant_oh;
                    w_pending_nx  = w_pending_nx & ~w_grant_oh;
                    w_last_nx     = r_grant;
                    w_busy_nx     = 1'b0;
                    w_state_nx    = S_IDLE;
                end
            end
            default: begin
                w_dp_start_nx = 1'b0;
                w_busy_nx     = 1'b0;
                w_state_nx    = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_finished <= '1;
            r_grant    <= '0;
            r_last     <= GRANT_WIDTH'(N_REQ - 1);
            r_dp_start <= 1'b0;
            r_dp_instr <= '0;
            r_result   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_pending  <= w_pending_nx;
            r_finished <= w_finished_nx;
            r_grant    <= w_grant_nx;
            r_last     <= w_last_nx;
            r_dp_start <= w_dp_start_nx;
            r_dp_instr <= w_dp_instr_nx;
            r_result   <= w_result_nx;
            r_busy     <= w_busy_nx;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                r_ibuf[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (w_capture[j]) begin
                    r_ibuf[j] <= req_instruction[j*INSTR_WIDTH +: INSTR_WIDTH];
                end
            end
        end
    end

    assign req_finished   = r_finished;
    assign req_result     = r_result;
    assign dp_start       = r_dp_start;
    assign dp_instruction = r_dp_instr;
    assign grant_id       = r_grant;
    assign busy           = r_busy;

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter
// Bench for dp_arbiter: a behavioural datapath responder, scripted and random
// client stimulus, a transaction-level reference model compared every cycle,
// and directed scenarios with hand-computed expectations.

module tb_dp_arbiter;

    localparam int N  = 4;
    localparam int GW = 2;
    localparam int IW = 16;
    localparam int RW = 16;

    logic            clock = 1'b0;
    logic            resetn;
    logic [N-1:0]    req_start;
    logic [N*IW-1:0] req_instruction;
    logic [N-1:0]    req_finished;
    logic [RW-1:0]   req_result;
    logic            dp_start;
    logic [IW-1:0]   dp_instruction;
    logic            dp_finished;
    logic [RW-1:0]   dp_result;
    logic [GW-1:0]   grant_id;
    logic            busy;

    dp_arbiter #(
        .N_REQ       (N),
        .GRANT_WIDTH (GW),
        .INSTR_WIDTH (IW),
        .RES_WIDTH   (RW)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .req_start       (req_start),
        .req_instruction (req_instruction),
        .req_finished    (req_finished),
        .req_result      (req_result),
        .dp_start        (dp_start),
        .dp_instruction  (dp_instruction),
        .dp_finished     (dp_finished),
        .dp_result       (dp_result),
        .grant_id        (grant_id),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural datapath ----------------
    int dp_lat_fixed = 3;   // 0 selects a random latency per operation

    function automatic logic [15:0] dp_func(input logic [15:0] ins);
        case (ins)
            16'h1234: return 16'h00AB;
            16'h0C00: return 16'h0011;
            16'h0C02: return 16'h0022;
            default:  return ins ^ 16'hBEEF;
        endcase
    endfunction

    initial begin : dp_model
        logic          st, rn;
        logic [IW-1:0] ins;
        int            cnt;
        logic [RW-1:0] pres;
        dp_finished = 1'b1;
        dp_result   = '0;
        cnt         = 0;
        pres        = '0;
        forever begin
            @(negedge clock);
            #1;
            st  = dp_start;
            rn  = resetn;
            ins = dp_instruction;
            @(posedge clock);
            #1;
            if (rn !== 1'b1) begin
                dp_finished = 1'b1;
                cnt         = 0;
            end else if (dp_finished) begin
                if (st === 1'b1) begin
                    dp_finished = 1'b0;
                    cnt  = (dp_lat_fixed > 0) ? dp_lat_fixed : int'($urandom_range(1, 6));
                    pres = dp_func(ins);
                end
            end else begin
                cnt--;
                if (cnt <= 0) begin
                    dp_finished = 1'b1;
                    dp_result   = pres;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Tracks requests as a pending set plus "age of the current grant" in
    // cycles; dp_start is expected during the first two cycles of a grant.
    bit            model_valid = 1'b0;
    logic [N-1:0]  m_pend;
    logic [IW-1:0] m_ibuf [N];
    int            m_last, m_grant, m_age;
    bit            m_busy;
    logic [IW-1:0] m_instr;
    logic [RW-1:0] m_result;

    initial begin : ref_model
        logic [N-1:0]    st, cap;
        logic [N*IW-1:0] ins;
        logic            df, rn;
        logic [RW-1:0]   dr;
        bit              found;
        int              idx;
        forever begin
            @(posedge clock);
            st = req_start; ins = req_instruction;
            df = dp_finished; dr = dp_result; rn = resetn;
            if (rn !== 1'b1) begin
                model_valid = 1'b1;
                m_pend = '0; m_last = N - 1; m_grant = 0; m_age = 0;
                m_busy = 1'b0; m_instr = '0; m_result = '0;
                for (int i = 0; i < N; i++) m_ibuf[i] = '0;
            end else begin
                cap = st & ~m_pend;
                if (m_busy) begin
                    if (m_age >= 1 && df) begin
                        m_busy   = 1'b0;
                        m_result = dr;
                        m_pend[m_grant] = 1'b0;
                        m_last   = m_grant;
                    end else begin
                        m_age++;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_last + k) % N;
                        if (!found && m_pend[idx]) begin
                            found   = 1'b1;
                            m_grant = idx;
                            m_instr = m_ibuf[idx];
                            m_busy  = 1'b1;
                            m_age   = 0;
                        end
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (cap[i]) begin
                        m_pend[i] = 1'b1;
                        m_ibuf[i] = ins[i*IW +: IW];
                    end
                end
            end
        end
    end

    initial begin : compare
        logic [N-1:0]  exp_fin;
        logic [GW-1:0] exp_gid;
        logic          exp_start;
        forever begin
            @(posedge clock);
            #2;
            if (model_valid) begin
                exp_fin   = ~m_pend;
                exp_gid   = GW'(m_grant);
                exp_start = m_busy && (m_age <= 1);
                check("req_finished",   req_finished,   exp_fin);
                check("dp_start",       dp_start,       exp_start);
                check("busy",           busy,           m_busy);
                check("grant_id",       grant_id,       exp_gid);
                check("dp_instruction", dp_instruction, m_instr);
                check("req_result",     req_result,     m_result);
            end
        end
    end

    // ---------------- client driver and recorders ----------------
    int            cyc = 0;
    int            pulse_left [N];
    int            reqs_left  [N];
    logic [IW-1:0] next_instr [N];
    bit            rand_mode = 1'b0;
    int            g_seq [$];
    logic [IW-1:0] i_seq [$];
    int            g_cyc [$];
    int            start_hi;
    int            rise_cnt  [N];
    int            rise_cyc  [N];
    logic [RW-1:0] last_res  [N];
    logic          prev_start = 1'b0;
    logic [N-1:0]  prev_fin   = '1;

    task automatic clear_rec();
        g_seq.delete(); i_seq.delete(); g_cyc.delete();
        start_hi = 0;
        for (int i = 0; i < N; i++) begin
            rise_cnt[i] = 0; rise_cyc[i] = 0; last_res[i] = '0;
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
        if (dp_start === 1'b1 && prev_start !== 1'b1) begin
            g_seq.push_back(int'(grant_id));
            i_seq.push_back(dp_instruction);
            g_cyc.push_back(cyc);
        end
        if (dp_start === 1'b1) start_hi++;
        for (int i = 0; i < N; i++) begin
            if (req_finished[i] === 1'b1 && prev_fin[i] !== 1'b1) begin
                rise_cnt[i]++;
                rise_cyc[i] = cyc;
                last_res[i] = req_result;
            end
        end
        prev_start = dp_start;
        prev_fin   = req_finished;
        for (int i = 0; i < N; i++) begin
            if (reqs_left[i] > 0 && pulse_left[i] == 0 && req_finished[i] === 1'b1) begin
                pulse_left[i] = 2;
                reqs_left[i]--;
                req_instruction[i*IW +: IW] = next_instr[i];
                next_instr[i] = next_instr[i] + 16'd1;
            end
            if (pulse_left[i] > 0) begin
                req_start[i] = 1'b1;
                pulse_left[i]--;
            end else if (rand_mode) begin
                req_start[i] = ($urandom_range(0, 3) == 0);
                req_instruction[i*IW +: IW] = 16'($urandom);
            end else begin
                req_start[i] = 1'b0;
            end
        end
        if (rand_mode) resetn = ($urandom_range(0, 199) != 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rst_finished"}, req_finished,   4'hF);
        check({tag, "_rst_dp_start"}, dp_start,       1'b0);
        check({tag, "_rst_busy"},     busy,           1'b0);
        check({tag, "_rst_grant"},    grant_id,       2'd0);
        check({tag, "_rst_instr"},    dp_instruction, 16'h0);
        check({tag, "_rst_result"},   req_result,     16'h0);
    endtask

    task automatic do_reset(input string tag);
        rand_mode = 1'b0;
        for (int i = 0; i < N; i++) begin
            reqs_left[i] = 0; pulse_left[i] = 0;
        end
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        check_reset_vals(tag);
        clear_rec();
    endtask

    task automatic wait_idle(input int maxc, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            step();
            done = (req_finished === '1) && (busy === 1'b0);
            for (int i = 0; i < N; i++)
                if (reqs_left[i] != 0 || pulse_left[i] != 0) done = 1'b0;
        end
        check({name, "_completes"}, done, 1'b1);
    endtask

    task automatic wait_grants(input int n, input string name);
        for (int k = 0; k < 30 && g_seq.size() < n; k++) step();
        check({name, "_grant_seen"}, (g_seq.size() >= n), 1'b1);
    endtask

    // ---------------- scenarios ----------------
    initial begin : main
        int c0;
        resetn = 1'b0;
        req_start = '0;
        req_instruction = '0;
        for (int i = 0; i < N; i++) begin
            pulse_left[i] = 0; reqs_left[i] = 0; next_instr[i] = '0;
        end
        clear_rec();

        // Single request, datapath latency 5
        do_reset("single");
        dp_lat_fixed = 5;
        next_instr[1] = 16'h1234;
        reqs_left[1] = 1;
        step();
        c0 = cyc;
        step();
        check("single_fin_drop", req_finished, 4'b1101);
        check("single_no_early_start", dp_start, 1'b0);
        wait_idle(60, "single");
        check("single_ngrants", g_seq.size(), 1);
        if (g_seq.size() >= 1) begin
            check("single_grant", g_seq[0], 1);
            check("single_instr", i_seq[0], 16'h1234);
            check("single_start_lat", g_cyc[0] - c0, 2);
        end
        check("single_start_cycles", start_hi, 2);
        check("single_result", last_res[1], 16'h00AB);
        check("single_done_lat", rise_cyc[1] - c0, 9);
        check("single_others", rise_cnt[0] + rise_cnt[2] + rise_cnt[3], 0);

        // Simultaneous clients 0 and 2
        do_reset("simul");
        dp_lat_fixed = 3;
        next_instr[0] = 16'h0C00;
        next_instr[2] = 16'h0C02;
        reqs_left[0] = 1;
        reqs_left[2] = 1;
        wait_idle(80, "simul");
        check("simul_ngrants", g_seq.size(), 2);
        if (g_seq.size() >= 2) begin
            check("simul_first", g_seq[0], 0);
            check("simul_second", g_seq[1], 2);
        end
        check("simul_res0", last_res[0], 16'h0011);
        check("simul_res2", last_res[2], 16'h0022);
        check("simul_order", rise_cyc[0] < rise_cyc[2], 1'b1);

        // Round robin, 12 grants, immediate re-request, random latency
        do_reset("rr");
        dp_lat_fixed = 0;
        for (int i = 0; i < N; i++) begin
            next_instr[i] = 16'(i * 256);
            reqs_left[i] = 3;
        end
        wait_idle(400, "rr");
        check("rr_ngrants", g_seq.size(), 12);
        for (int k = 0; k < g_seq.size() && k < 12; k++)
            check("rr_order", g_seq[k], k % 4);

        // Request while busy
        do_reset("busy");
        dp_lat_fixed = 8;
        next_instr[0] = 16'h0A00;
        reqs_left[0] = 1;
        wait_grants(1, "busy");
        step();
        step();
        next_instr[3] = 16'h3333;
        reqs_left[3] = 1;
        step();
        step();
        check("busy_fin3_drop", req_finished[3], 1'b0);
        check("busy_no_start", dp_start, 1'b0);
        wait_idle(80, "busy");
        check("busy_ngrants", g_seq.size(), 2);
        if (g_seq.size() >= 2) begin
            check("busy_second", g_seq[1], 3);
            check("busy_instr3", i_seq[1], 16'h3333);
            check("busy_after_done", g_cyc[1] - rise_cyc[0], 1);
        end
        check("busy_res3", last_res[3], dp_func(16'h3333));

        // Reset mid-WAIT
        do_reset("midrst");
        dp_lat_fixed = 10;
        next_instr[2] = 16'h2200;
        reqs_left[2] = 1;
        wait_grants(1, "midrst");
        step();
        step();
        check("midrst_waiting", busy, 1'b1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check_reset_vals("midrst");
        clear_rec();
        dp_lat_fixed = 3;
        next_instr[2] = 16'h2222;
        reqs_left[2] = 1;
        wait_idle(60, "midrst2");
        check("midrst_ngrants", g_seq.size(), 1);
        if (g_seq.size() >= 1) check("midrst_grant", g_seq[0], 2);
        check("midrst_result", last_res[2], 16'h9CCD);

        // Back-to-back same client
        do_reset("b2b");
        dp_lat_fixed = 2;
        next_instr[1] = 16'hB001;
        reqs_left[1] = 2;
        wait_idle(80, "b2b");
        check("b2b_ngrants", g_seq.size(), 2);
        if (g_seq.size() >= 2) begin
            check("b2b_g0", g_seq[0], 1);
            check("b2b_g1", g_seq[1], 1);
            check("b2b_i0", i_seq[0], 16'hB001);
            check("b2b_i1", i_seq[1], 16'hB002);
        end
        check("b2b_start_cycles", start_hi, 4);
        check("b2b_rises", rise_cnt[1], 2);
        check("b2b_result", last_res[1], dp_func(16'hB002));

        // Random traffic with occasional resets; the model checks every cycle
        do_reset("rand");
        dp_lat_fixed = 0;
        rand_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 30) == 0) reqs_left[$urandom_range(0, N-1)] = 1;
            step();
        end
        rand_mode = 1'b0;
        resetn = 1'b1;
        wait_idle(300, "rand_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
